banco_coef_rx: RTL and testbench
================================

# banco_coef_rx

Receiving end of the coefficient-load protocol for the 16-tap FIR datapath. It accepts a load-start strobe and one 12-bit signed coefficient per change strobe from the front-panel or test driver. It stores the coefficients in a 16-entry register bank and reports block completion on `fin_block_coef_o`. The FIR MAC reads taps through a registered read port and only uses them while `coef_valid_o` is high.

## Interface
- `N_COEF`, 16: coefficients per block; must be a power of two, ≤ 16.
- `COEF_W`, 12: coefficient width, two's complement.
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: reset, asynchronous assert, active-low. Release must be synchronous to `clk` externally.
- `carga_i` in 1: load-start strobe, asynchronous level.
- `cambio_i` in 1: coefficient strobe, asynchronous level; one coefficient per rising edge.
- `coef_i` in COEF_W: coefficient value, signed.
- `rd_addr_i` in log2(N_COEF): tap read address from the FIR.
- `rd_coef_o` out COEF_W: coefficient at `rd_addr_i`, registered.
- `coef_idx_o` out log2(N_COEF): index the next strobe will write.
- `busy_o` out 1: high in LOAD.
- `fin_block_coef_o` out 1: one-cycle pulse when the last coefficient is written.
- `coef_valid_o` out 1: bank holds a complete block.
- `ovf_o` out 1: sticky; a strobe arrived outside LOAD.

## Operation
- Input conditioning:
  - `carga_i` and `cambio_i` each pass through a 2-FF synchronizer and then a rising-edge detector, giving the internal pulses `carga_p` and `cambio_p` (one cycle each).
  - `coef_i` is not synchronized. It is sampled in the cycle `cambio_p` is high.
- States: IDLE, LOAD, DONE.
- IDLE:
  - `carga_p` → LOAD, with `coef_idx_o` ← 0, `coef_valid_o` ← 0, `ovf_o` ← 0.
  - `cambio_p` → `ovf_o` ← 1; no write.
- LOAD:
  - `cambio_p` → bank[`coef_idx_o`] ← `coef_i`, then `coef_idx_o` increments.
  - If the written index is N_COEF-1: go to DONE, `fin_block_coef_o` = 1 for exactly one cycle, `coef_valid_o` ← 1, and `coef_idx_o` wraps to 0.
- DONE:
  - `carga_p` → LOAD, same actions as in IDLE.
  - `cambio_p` → `ovf_o` ← 1; no write; bank unchanged.
- `carga_p` in LOAD: restart. Index goes to 0, entries already written are kept, and they are overwritten by the new block.
- `carga_p` and `cambio_p` in the same cycle: `carga_p` wins and `cambio_p` is discarded. No write, no `ovf_o`.
- Bank entries are not cleared by `carga_p`; only reset clears them.
- Read port: `rd_coef_o` ← bank[`rd_addr_i`] every cycle, independent of state.
- A write and a read to the same address in the same cycle: `rd_coef_o` returns the old value and shows the new one the next cycle.
- Values are stored verbatim, with no sign extension or saturation.

## Timing
- Reset (`rst` = 0): state IDLE; all 16 entries 0; `rd_coef_o` = 0, `coef_idx_o` = 0, `busy_o` = 0, `fin_block_coef_o` = 0, `coef_valid_o` = 0, `ovf_o` = 0; synchronizer flops 0.
- Reset mid-LOAD aborts the block and clears the bank. The first strobe after release writes index 0 only after a new `carga_i`.
- Strobe latency: strobe rise sampled at edge k → `cambio_p` high between k+1 and k+2 → write at edge k+2.
  - `coef_idx_o` and `fin_block_coef_o` update at k+2.
  - The new value appears on `rd_coef_o` at k+3 if it is addressed.
- `coef_i` must be stable from strobe rise through edge k+2.
- Strobe high time ≥ 2 clk cycles and low time ≥ 2 clk cycles. Shorter pulses may be missed; the block does not count them.
- A strobe held high indefinitely produces exactly one write.
- `busy_o` is high from the cycle after the `carga_p` edge through the cycle in which the last write occurs.

## Test plan
- Reset, then `carga_i` followed by 16 strobes with -99, 65, 136, 33, -156, -86, 376, 854, 854, 376, -86, -156, 33, 136, 65, -99 (each strobe high 3 cycles, low 3 cycles):
  - `fin_block_coef_o` pulses once, 2 cycles after the 16th strobe is sampled.
  - `coef_valid_o` = 1.
  - Reading addresses 0..15 returns 12'hF9D, 12'h041, 12'h088, …, 12'hF9D.
- After a complete load, a 17th strobe with value 7: `ovf_o` = 1, entry 0 still 12'hF9D, `coef_valid_o` stays 1.
- `carga_i` mid-block after 5 strobes, then 16 strobes with values 1..16:
  - `coef_idx_o` returns to 0.
  - Final bank holds 1..16.
  - `fin_block_coef_o` pulses only once.
- `carga_i` and `cambio_i` rise in the same clk cycle: no write, `coef_idx_o` = 0, state LOAD, `ovf_o` = 0.
- 1-cycle `cambio_i` pulse, 10 ns wide at 10 ns clk: at most one write; a strobe held high 20 cycles gives exactly one write.
- `rst` = 0 asserted asynchronously mid-LOAD (between clock edges): all outputs go to their reset values immediately, without waiting for a clock edge, and the bank reads all zeros after release.

Source files
------------

// File: rtl/banco_coef_rx.sv
// Coefficient-load receiver for the 16-tap FIR: synchronizes the load/change
// strobes, writes one signed coefficient per strobe into a register bank and
// serves a registered read port to the MAC.
module banco_coef_rx #(
  parameter  int N_COEF = 16,
  parameter  int COEF_W = 12,
  localparam int IDX_W  = $clog2(N_COEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     carga_i,
  input  logic                     cambio_i,
  input  logic signed [COEF_W-1:0] coef_i,
  input  logic        [IDX_W-1:0]  rd_addr_i,
  output logic signed [COEF_W-1:0] rd_coef_o,
  output logic        [IDX_W-1:0]  coef_idx_o,
  output logic                     busy_o,
  output logic                     fin_block_coef_o,
  output logic                     coef_valid_o,
  output logic                     ovf_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic                     r_carga_s1, r_carga_s2, r_carga_d;
  logic                     r_cambio_s1, r_cambio_s2, r_cambio_d;
  logic [1:0]               r_state;
  logic [IDX_W-1:0]         r_idx;
  logic                     r_fin;
  logic                     r_valid;
  logic                     r_ovf;
  logic signed [COEF_W-1:0] r_bank [N_COEF];
  logic signed [COEF_W-1:0] r_rd;

  logic w_carga_p;
  logic w_cambio_p;
  logic w_wr;
  logic w_last;

  // Two-flop synchronizers followed by a rising-edge detector per strobe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_carga_s1  <= 1'b0;
      r_carga_s2  <= 1'b0;
      r_carga_d   <= 1'b0;
      r_cambio_s1 <= 1'b0;
      r_cambio_s2 <= 1'b0;
      r_cambio_d  <= 1'b0;
    end else begin
      r_carga_s1  <= carga_i;
      r_carga_s2  <= r_carga_s1;
      r_carga_d   <= r_carga_s2;
      r_cambio_s1 <= cambio_i;
      r_cambio_s2 <= r_cambio_s1;
      r_cambio_d  <= r_cambio_s2;
    end
  end

  assign w_carga_p  = r_carga_s2 & ~r_carga_d;
  assign w_cambio_p = r_cambio_s2 & ~r_cambio_d;
  // A load-start in the same cycle swallows the coefficient strobe
  assign w_wr       = (r_state == S_LOAD) && w_cambio_p && !w_carga_p;
  assign w_last     = w_wr && (r_idx == IDX_W'(N_COEF - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_fin   <= 1'b0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_fin <= w_last;
      if (w_carga_p) begin
        r_state <= S_LOAD;
        r_idx   <= '0;
        r_valid <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (w_cambio_p) begin
        if (r_state == S_LOAD) begin
          if (w_last) begin
            r_state <= S_DONE;
            r_idx   <= '0;
            r_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // Bank and read port; a same-cycle write/read returns the old entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_COEF; i++) r_bank[i] <= '0;
      r_rd <= '0;
    end else begin
      if (w_wr) r_bank[r_idx] <= coef_i;
      r_rd <= r_bank[rd_addr_i];
    end
  end

  assign rd_coef_o        = r_rd;
  assign coef_idx_o       = r_idx;
  assign busy_o           = (r_state == S_LOAD);
  assign fin_block_coef_o = r_fin;
  assign coef_valid_o     = r_valid;
  assign ovf_o            = r_ovf;

endmodule

// File: tb/tb_banco_coef_rx.sv
// Directed bench for banco_coef_rx: full load, overflow, restart, strobe
// collision, pulse-width handling and asynchronous reset.
module tb_banco_coef_rx;

  logic               clk;
  logic               rst;
  logic               carga_i;
  logic               cambio_i;
  logic signed [11:0] coef_i;
  logic        [3:0]  rd_addr_i;
  logic signed [11:0] rd_coef_o;
  logic        [3:0]  coef_idx_o;
  logic               busy_o;
  logic               fin_block_coef_o;
  logic               coef_valid_o;
  logic               ovf_o;

  int n_checks = 0;
  int n_errors = 0;
  int fin_cnt  = 0;

  logic [11:0] exp_sym [16] = '{12'hF9D, 12'h041, 12'h088, 12'h021, 12'hF64, 12'hFAA,
                                12'h178, 12'h356, 12'h356, 12'h178, 12'hFAA, 12'hF64,
                                12'h021, 12'h088, 12'h041, 12'hF9D};

  banco_coef_rx #(.N_COEF(16), .COEF_W(12)) dut (
    .clk(clk), .rst(rst), .carga_i(carga_i), .cambio_i(cambio_i), .coef_i(coef_i),
    .rd_addr_i(rd_addr_i), .rd_coef_o(rd_coef_o), .coef_idx_o(coef_idx_o),
    .busy_o(busy_o), .fin_block_coef_o(fin_block_coef_o),
    .coef_valid_o(coef_valid_o), .ovf_o(ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (fin_block_coef_o === 1'b1) fin_cnt++;

  // Strobe high 3 cycles, low 3; f2/f3 = fin seen after edges k+1 and k+2
  task automatic strobe(input logic [11:0] v, output logic f2, output logic f3);
    @(negedge clk); coef_i = v; cambio_i = 1'b1;
    @(negedge clk);
    @(negedge clk); f2 = fin_block_coef_o;
    @(negedge clk); f3 = fin_block_coef_o; cambio_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic carga();
    @(negedge clk); carga_i = 1'b1;
    repeat (3) @(negedge clk);
    carga_i = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic read_at(input logic [3:0] a, output logic [11:0] v);
    @(negedge clk); rd_addr_i = a;
    @(negedge clk); v = rd_coef_o;
  endtask

  task automatic test_reset();
    logic [11:0] v;
    rst = 1'b0; carga_i = 1'b0; cambio_i = 1'b0; coef_i = '0; rd_addr_i = '0;
    #12;
    n_checks++; if (rd_coef_o !== 12'h000) begin n_errors++; $display("FAIL reset_rd got %h want 000", rd_coef_o); end
    n_checks++; if (coef_idx_o !== 4'd0) begin n_errors++; $display("FAIL reset_idx got %0d want 0", coef_idx_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_checks++; if (fin_block_coef_o !== 1'b0) begin n_errors++; $display("FAIL reset_fin got %b want 0", fin_block_coef_o); end
    n_checks++; if (coef_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", coef_valid_o); end
    n_checks++; if (ovf_o !== 1'b0) begin n_errors++; $display("FAIL reset_ovf got %b want 0", ovf_o); end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    read_at(4'd5, v);
    n_checks++; if (v !== 12'h000) begin n_errors++; $display("FAIL reset_bank5 got %h want 000", v); end
  endtask

  task automatic test_full_load();
    logic f2, f3;
    logic [11:0] v;
    int fin0;
    carga();
    n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL load_busy got %b want 1", busy_o); end
    n_checks++; if (coef_idx_o !== 4'd0) begin n_errors++; $display("FAIL load_idx0 got %0d want 0", coef_idx_o); end
    fin0 = fin_cnt;
    for (int i = 0; i < 16; i++) strobe(exp_sym[i], f2, f3);
    n_checks++; if (f2 !== 1'b0) begin n_errors++; $display("FAIL fin_early got %b want 0", f2); end
    n_checks++; if (f3 !== 1'b1) begin n_errors++; $display("FAIL fin_at_k2 got %b want 1", f3); end
    n_checks++; if (fin_cnt - fin0 !== 1) begin n_errors++; $display("FAIL fin_count got %0d want 1", fin_cnt - fin0); end
    n_checks++; if (coef_valid_o !== 1'b1) begin n_errors++; $display("FAIL load_valid got %b want 1", coef_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL load_busy_end got %b want 0", busy_o); end
    n_checks++; if (coef_idx_o !== 4'd0) begin n_errors++; $display("FAIL load_idx_wrap got %0d want 0", coef_idx_o); end
    for (int i = 0; i < 16; i++) begin
      read_at(4'(i), v);
      n_checks++; if (v !== exp_sym[i]) begin n_errors++; $display("FAIL load_bank[%0d] got %h want %h", i, v, exp_sym[i]); end
    end
  endtask

  task automatic test_overflow();
    logic f2, f3;
    logic [11:0] v;
    strobe(12'h007, f2, f3);
    n_checks++; if (ovf_o !== 1'b1) begin n_errors++; $display("FAIL ovf_set got %b want 1", ovf_o); end
    n_checks++; if (coef_valid_o !== 1'b1) begin n_errors++; $display("FAIL ovf_valid got %b want 1", coef_valid_o); end
    n_checks++; if (f3 !== 1'b0) begin n_errors++; $display("FAIL ovf_fin got %b want 0", f3); end
    read_at(4'd0, v);
    n_checks++; if (v !== 12'hF9D) begin n_errors++; $display("FAIL ovf_bank0 got %h want F9D", v); end
  endtask

  task automatic test_restart();
    logic f2, f3;
    logic [11:0] v;
    int fin0;
    carga();
    n_checks++; if (ovf_o !== 1'b0) begin n_errors++; $display("FAIL restart_ovf_clr got %b want 0", ovf_o); end
    n_checks++; if (coef_valid_o !== 1'b0) begin n_errors++; $display("FAIL restart_valid_clr got %b want 0", coef_valid_o); end
    for (int i = 0; i < 5; i++) strobe(12'(100 + i), f2, f3);
    n_checks++; if (coef_idx_o !== 4'd5) begin n_errors++; $display("FAIL restart_idx5 got %0d want 5", coef_idx_o); end
    carga();
    n_checks++; if (coef_idx_o !== 4'd0) begin n_errors++; $display("FAIL restart_idx0 got %0d want 0", coef_idx_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL restart_busy got %b want 1", busy_o); end
    fin0 = fin_cnt;
    for (int i = 0; i < 16; i++) strobe(12'(i + 1), f2, f3);
    n_checks++; if (fin_cnt - fin0 !== 1) begin n_errors++; $display("FAIL restart_fin_count got %0d want 1", fin_cnt - fin0); end
    for (int i = 0; i < 16; i++) begin
      read_at(4'(i), v);
      n_checks++; if (v !== 12'(i + 1)) begin n_errors++; $display("FAIL restart_bank[%0d] got %h want %h", i, v, 12'(i + 1)); end
    end
  endtask

  task automatic test_collision();
    logic [11:0] v;
    @(negedge clk); carga_i = 1'b1; cambio_i = 1'b1; coef_i = 12'h555;
    repeat (3) @(negedge clk);
    carga_i = 1'b0; cambio_i = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (coef_idx_o !== 4'd0) begin n_errors++; $display("FAIL coll_idx got %0d want 0", coef_idx_o); end
    n_checks++; if (busy_o !== 1'b1) begin n_errors++; $display("FAIL coll_busy got %b want 1", busy_o); end
    n_checks++; if (ovf_o !== 1'b0) begin n_errors++; $display("FAIL coll_ovf got %b want 0", ovf_o); end
    read_at(4'd0, v);
    n_checks++; if (v !== 12'h001) begin n_errors++; $display("FAIL coll_bank0 got %h want 001", v); end
  endtask

  task automatic test_pulse_width();
    logic [11:0] v;
    @(negedge clk); coef_i = 12'h7FF; cambio_i = 1'b1;
    @(negedge clk); cambio_i = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (coef_idx_o !== 4'd1) begin n_errors++; $display("FAIL short_idx got %0d want 1", coef_idx_o); end
    @(negedge clk); coef_i = 12'h123; cambio_i = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (coef_idx_o !== 4'd2) begin n_errors++; $display("FAIL held_idx got %0d want 2", coef_idx_o); end
    cambio_i = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (coef_idx_o !== 4'd2) begin n_errors++; $display("FAIL held_idx_after got %0d want 2", coef_idx_o); end
    read_at(4'd1, v);
    n_checks++; if (v !== 12'h123) begin n_errors++; $display("FAIL held_bank1 got %h want 123", v); end
    read_at(4'd0, v);
    n_checks++; if (v !== 12'h7FF) begin n_errors++; $display("FAIL short_bank0 got %h want 7FF", v); end
  endtask

  task automatic test_async_reset();
    logic f2, f3;
    logic [11:0] v;
    @(posedge clk); #2 rst = 1'b0;
    #1;
    n_checks++; if (rd_coef_o !== 12'h000) begin n_errors++; $display("FAIL arst_rd got %h want 000", rd_coef_o); end
    n_checks++; if (coef_idx_o !== 4'd0) begin n_errors++; $display("FAIL arst_idx got %0d want 0", coef_idx_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL arst_busy got %b want 0", busy_o); end
    n_checks++; if (coef_valid_o !== 1'b0 || ovf_o !== 1'b0 || fin_block_coef_o !== 1'b0) begin
      n_errors++; $display("FAIL arst_flags got %b%b%b want 000", coef_valid_o, ovf_o, fin_block_coef_o); end
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      read_at(4'(i), v);
      n_checks++; if (v !== 12'h000) begin n_errors++; $display("FAIL arst_bank[%0d] got %h want 000", i, v); end
    end
    strobe(12'h0AA, f2, f3);
    n_checks++; if (ovf_o !== 1'b1) begin n_errors++; $display("FAIL arst_strobe_ovf got %b want 1", ovf_o); end
    n_checks++; if (coef_idx_o !== 4'd0) begin n_errors++; $display("FAIL arst_strobe_idx got %0d want 0", coef_idx_o); end
    read_at(4'd0, v);
    n_checks++; if (v !== 12'h000) begin n_errors++; $display("FAIL arst_strobe_bank0 got %h want 000", v); end
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_overflow();
    test_restart();
    test_collision();
    test_pulse_width();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
